// File: rtl/keccak_sponge_ctrl_pkg.sv
// Shared constants and FSM encoding for the Keccak sponge controller.
// Latency: n/a (declarations only). Backpressure: n/a.
// Holds the round count, the digest drain length and the controller state enum.
package pkg_keccak;

  localparam int NUM_ROUNDS          = 24;
  localparam int OUT_BUF_SIZE        = 64;
  localparam int COUNT_OUT_WORD_SIZE = $clog2(OUT_BUF_SIZE) - 1;
  localparam int DRAIN_CYCLES        = COUNT_OUT_WORD_SIZE + 1;
  localparam int RND_W               = 5;

  localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(NUM_ROUNDS - 1);
  localparam logic [RND_W-1:0] LAST_DRAIN = RND_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_BLK,
    PERMUTE,
    SQUEEZE,
    DRAIN
  } state_t;

endpackage

// File: rtl/keccak_round_cnt.sv
// Wrapping cycle counter shared by the permutation rounds and the digest drain.
// Latency: count updates one cycle after enable. Backpressure: none, free-running while enabled.
// terminal is high while count equals last_val; the next enabled cycle wraps to zero.
module keccak_round_cnt
  import pkg_keccak::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [RND_W-1:0] last_val,
  output logic [RND_W-1:0] count,
  output logic             terminal
);

  assign terminal = (count == last_val);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + RND_W'(1);
    end
  end

endmodule

// File: rtl/keccak_sponge_ctrl.sv
// Sequencing FSM for a Keccak sponge: clear, absorb 1024-bit blocks, run 24 rounds, squeeze, drain.
// Latency: block accept to next Ready is 25 cycles. Backpressure: blocks are held off until WAIT_BLK.
// Outputs decode registered state only; Absorb_en additionally follows Din_buffer_full.
module keccak_sponge_ctrl
  import pkg_keccak::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Din_buffer_full,
  input  logic             Last_block,
  output logic             Ready,
  output logic             State_clear,
  output logic             Absorb_en,
  output logic             Round_en,
  output logic [RND_W-1:0] Round_num,
  output logic             Busy,
  output logic             Done
);

  state_t           state_q;
  state_t           state_d;
  logic             last_q;
  logic             cnt_en;
  logic [RND_W-1:0] cnt_last;
  logic [RND_W-1:0] cnt;
  logic             cnt_term;

  // One counter serves both phases; it wraps to zero leaving PERMUTE, so DRAIN starts at zero.
  keccak_round_cnt u_round_cnt (
    .Clock    (Clock),
    .Reset    (Reset),
    .clear    (Absorb_en),
    .enable   (cnt_en),
    .last_val (cnt_last),
    .count    (cnt),
    .terminal (cnt_term)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (Absorb_en) begin
        last_q <= Last_block;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    Ready       = 1'b0;
    State_clear = 1'b0;
    Absorb_en   = 1'b0;
    Round_en    = 1'b0;
    Done        = 1'b0;
    cnt_en      = 1'b0;
    cnt_last    = LAST_ROUND;
    case (state_q)
      IDLE: begin
        if (Start) state_d = CLEAR;
      end
      CLEAR: begin
        State_clear = 1'b1;
        state_d     = WAIT_BLK;
      end
      WAIT_BLK: begin
        Ready = 1'b1;
        if (Din_buffer_full) begin
          Absorb_en = 1'b1;
          state_d   = PERMUTE;
        end
      end
      PERMUTE: begin
        Round_en = 1'b1;
        cnt_en   = 1'b1;
        if (cnt_term) state_d = last_q ? SQUEEZE : WAIT_BLK;
      end
      SQUEEZE: begin
        Ready   = 1'b1;
        state_d = DRAIN;
      end
      DRAIN: begin
        cnt_en   = 1'b1;
        cnt_last = LAST_DRAIN;
        if (cnt_term) begin
          Done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Round_num = (state_q == PERMUTE) ? cnt : '0;
  assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// Directed bench for keccak_sponge_ctrl: single block, three blocks, Start ignored while busy,
// and asynchronous reset in the middle of the permutation.
module tb_keccak_sponge_ctrl;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Din_buffer_full;
  logic       Last_block;
  logic       Ready;
  logic       State_clear;
  logic       Absorb_en;
  logic       Round_en;
  logic [4:0] Round_num;
  logic       Busy;
  logic       Done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 Clock = ~Clock;

  keccak_sponge_ctrl dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .Start           (Start),
    .Din_buffer_full (Din_buffer_full),
    .Last_block      (Last_block),
    .Ready           (Ready),
    .State_clear     (State_clear),
    .Absorb_en       (Absorb_en),
    .Round_en        (Round_en),
    .Round_num       (Round_num),
    .Busy            (Busy),
    .Done            (Done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic adv();
    @(posedge Clock);
    #1;
  endtask

  task automatic smp();
    @(negedge Clock);
    check("excl", 32'($countones({State_clear, Absorb_en, Round_en}) <= 1), 1);
    check("rnd_lt24", 32'(Round_num < 5'd24), 1);
  endtask

  initial begin
    int  n_abs;
    int  n_rnd;
    int  n_done;
    int  last_abs;
    bit  got_done;

    Reset = 1'b1;
    Start = 1'b0;
    Din_buffer_full = 1'b0;
    Last_block = 1'b0;
    smp();
    smp();
    check("rst_outs", 32'({Ready, State_clear, Absorb_en, Round_en, Round_num, Busy, Done}), 0);

    // Single final block; Start pulses during PERMUTE and DRAIN must be ignored.
    adv(); Reset = 1'b0; Start = 1'b1;
    smp();
    check("a_idle_busy", 32'(Busy), 0);
    check("a_idle_ready", 32'(Ready), 0);
    adv(); Start = 1'b0; Din_buffer_full = 1'b1; Last_block = 1'b1;
    smp();
    check("a_clear", 32'(State_clear), 1);
    check("a_clear_busy", 32'(Busy), 1);
    check("a_clear_absorb", 32'(Absorb_en), 0);
    check("a_clear_ready", 32'(Ready), 0);
    adv();
    smp();
    check("a_wb_ready", 32'(Ready), 1);
    check("a_wb_absorb", 32'(Absorb_en), 1);
    check("a_wb_clear", 32'(State_clear), 0);
    for (int r = 0; r < 24; r++) begin
      adv(); Din_buffer_full = 1'b0; Last_block = 1'b0; Start = (r == 5);
      smp();
      check("a_rnd_en", 32'(Round_en), 1);
      check("a_rnd_num", 32'(Round_num), r);
      check("a_rnd_ready", 32'(Ready), 0);
    end
    adv(); Start = 1'b0;
    smp();
    check("a_sq_ready", 32'(Ready), 1);
    check("a_sq_rnd_en", 32'(Round_en), 0);
    check("a_sq_rnd_num", 32'(Round_num), 0);
    for (int k = 1; k <= 6; k++) begin
      adv(); Start = (k == 2);
      smp();
      check("a_drain_ready", 32'(Ready), 0);
      check("a_drain_done", 32'(Done), 32'(k == 6));
      check("a_drain_busy", 32'(Busy), 1);
    end
    adv(); Start = 1'b0;
    smp();
    check("a_end_busy", 32'(Busy), 0);
    check("a_end_done", 32'(Done), 0);

    // Three blocks with the buffer always full; Last_block is high during rounds to prove
    // it only matters at absorb time, and high at the third absorb.
    adv(); Start = 1'b1; Din_buffer_full = 1'b1; Last_block = 1'b0;
    smp();
    adv(); Start = 1'b0;
    smp();
    check("b_clear", 32'(State_clear), 1);
    n_abs = 0; n_rnd = 0; last_abs = 0; got_done = 1'b0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      adv(); Last_block = (n_abs == 2) || Round_en;
      smp();
      if (Absorb_en) begin
        if (n_abs > 0) check("b_gap", c - last_abs, 25);
        last_abs = c;
        n_abs++;
      end
      if (Round_en) n_rnd++;
      if (Done) got_done = 1'b1;
    end
    check("b_done_seen", 32'(got_done), 1);
    check("b_absorbs", n_abs, 3);
    check("b_rounds", n_rnd, 72);
    n_done = 0;
    n_abs = 0;
    for (int c = 0; c < 8; c++) begin
      adv();
      smp();
      if (Done) n_done++;
      if (Absorb_en) n_abs++;
    end
    check("b_extra_done", n_done, 0);
    check("b_extra_absorb", n_abs, 0);
    check("b_idle_busy", 32'(Busy), 0);

    // Asynchronous reset at round 10, then a clean restart.
    adv(); Start = 1'b1; Din_buffer_full = 1'b0; Last_block = 1'b0;
    smp();
    adv(); Start = 1'b0; Din_buffer_full = 1'b1;
    smp();
    adv();
    smp();
    check("c_absorb", 32'(Absorb_en), 1);
    adv(); Din_buffer_full = 1'b0;
    smp();
    for (int i = 0; i < 30 && Round_num != 5'd10; i++) begin
      adv();
      smp();
    end
    check("c_at10", 32'(Round_num), 10);
    #2 Reset = 1'b1;
    #1;
    check("c_async_rst", 32'({Ready, State_clear, Absorb_en, Round_en, Round_num, Busy, Done}), 0);
    adv();
    adv(); Reset = 1'b0; Start = 1'b1;
    smp();
    check("c_idle_busy", 32'(Busy), 0);
    adv(); Start = 1'b0;
    smp();
    check("c_clear", 32'(State_clear), 1);
    adv(); Din_buffer_full = 1'b1; Last_block = 1'b1;
    smp();
    check("c_wb_ready", 32'(Ready), 1);
    check("c_absorb2", 32'(Absorb_en), 1);
    adv(); Din_buffer_full = 1'b0; Last_block = 1'b0;
    smp();
    check("c_rnd_en", 32'(Round_en), 1);
    check("c_rnd0", 32'(Round_num), 0);
    got_done = 1'b0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      adv();
      smp();
      if (Done) got_done = 1'b1;
    end
    check("c_done_seen", 32'(got_done), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
